// File: rtl/ahb_dma_pri_dec_arb_if.sv
// Arbiter-side bundle: per-channel requests and one-hot priorities in,
// registered grant out to the DMA master engine.
interface ahb_dma_pri_dec_arb_if #(
    parameter int NCH = 8
);
    localparam int CHW = $clog2(NCH);

    logic [NCH-1:0]   ch_req;
    logic [NCH*8-1:0] ch_pri;
    logic             pause;
    logic             done;
    logic             grant_valid;
    logic [CHW-1:0]   grant_ch;
    logic [NCH-1:0]   grant_oh;
    logic [2:0]       grant_pri;

    modport slave (
        input  ch_req, ch_pri, pause, done,
        output grant_valid, grant_ch, grant_oh, grant_pri
    );

    modport master (
        output ch_req, ch_pri, pause, done,
        input  grant_valid, grant_ch, grant_oh, grant_pri
    );
endinterface

// File: rtl/ahb_dma_pri_dec_arb.sv
// DMA channel arbiter: decodes one-hot priorities, picks highest level with
// round-robin among equals, and holds a registered grant until release.

// Per-channel decode: highest set bit wins, all-zero vector flags ineligible.
module ahb_dma_pri_lvl_dec (
    input  logic [7:0] vec,
    output logic [2:0] lvl,
    output logic       nz
);
    always_comb begin
        lvl = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (vec[b]) lvl = 3'(b);
        end
        nz = |vec;
    end
endmodule

module ahb_dma_pri_dec_arb #(
    parameter int NCH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ahb_dma_pri_dec_arb_if.slave bus
);
    localparam int CHW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

    state_t               state, state_nxt;
    logic [NCH-1:0][2:0]  lvl;
    logic [NCH-1:0]       nz;
    logic [NCH-1:0]       elig;
    logic [NCH-1:0]       cand;
    logic [2:0]           max_pri;
    logic [CHW-1:0]       last_ch;
    logic [CHW-1:0]       win_ch;
    logic [CHW-1:0]       scan;
    logic                 win_found;
    logic                 load;
    logic                 rel;

    logic                 grant_valid;
    logic [CHW-1:0]       grant_ch;
    logic [NCH-1:0]       grant_oh;
    logic [2:0]           grant_pri;

    for (genvar i = 0; i < NCH; i++) begin : g_dec
        ahb_dma_pri_lvl_dec u_dec (
            .vec (bus.ch_pri[8*i +: 8]),
            .lvl (lvl[i]),
            .nz  (nz[i])
        );
    end

    assign elig = bus.ch_req & nz;

    always_comb begin
        max_pri = 3'd0;
        for (int i = 0; i < NCH; i++) begin
            if (elig[i] && lvl[i] > max_pri) max_pri = lvl[i];
        end
        cand = '0;
        for (int i = 0; i < NCH; i++) begin
            cand[i] = elig[i] && (lvl[i] == max_pri);
        end
    end

    // Scan starts one past the last granted channel; explicit wrap keeps
    // non-power-of-two channel counts correct.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        scan      = last_ch;
        for (int k = 0; k < NCH; k++) begin
            scan = (scan == CHW'(NCH-1)) ? '0 : scan + CHW'(1);
            if (!win_found && cand[scan]) begin
                win_found = 1'b1;
                win_ch    = scan;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rel       = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.pause && win_found) begin
                    load      = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // done and withdrawal in the same cycle collapse to one release
                if (bus.done || !bus.ch_req[grant_ch]) begin
                    rel       = 1'b1;
                    state_nxt = HOLDOFF;
                end
            end
            HOLDOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_valid <= 1'b0;
            grant_ch    <= '0;
            grant_oh    <= '0;
            grant_pri   <= 3'd0;
            last_ch     <= CHW'(NCH-1);
        end else if (load) begin
            grant_valid <= 1'b1;
            grant_ch    <= win_ch;
            grant_oh    <= NCH'(1) << win_ch;
            grant_pri   <= max_pri;
        end else if (rel) begin
            grant_valid <= 1'b0;
            grant_oh    <= '0;
            last_ch     <= grant_ch;
        end
    end

    assign bus.grant_valid = grant_valid;
    assign bus.grant_ch    = grant_ch;
    assign bus.grant_oh    = grant_oh;
    assign bus.grant_pri   = grant_pri;
endmodule

// File: tb/tb_ahb_dma_pri_dec_arb.sv
// Directed bench for the DMA channel arbiter: vector table plus corner sequences.
module tb_ahb_dma_pri_dec_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_dma_pri_dec_arb_if #(.NCH(8)) bus();
    ahb_dma_pri_dec_arb #(.NCH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  req;
        logic [63:0] pri;
        logic        pause;
        bit          v;
        int          ch;
        int          pr;
    } vec_t;

    vec_t tbl[11];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_grant(string tag, bit v, int ch, int pr);
        check({tag, ".valid"}, 64'(bus.grant_valid), 64'(v));
        if (v) begin
            check({tag, ".ch"},  64'(bus.grant_ch),  64'(ch));
            check({tag, ".oh"},  64'(bus.grant_oh),  64'd1 << ch);
            check({tag, ".pri"}, 64'(bus.grant_pri), 64'(pr));
        end else begin
            check({tag, ".oh0"}, 64'(bus.grant_oh), 64'd0);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ch_req = '0; bus.ch_pri = '0; bus.pause = 1'b0; bus.done = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
    endtask

    initial begin
        int rr_exp[6];
        rr_exp = '{1, 3, 6, 1, 3, 6};

        tbl[0]  = '{8'h05, 64'h0000_0000_0010_0004, 1'b0, 1'b1, 2, 4};
        tbl[1]  = '{8'h10, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{8'h10, 64'h0000_0024_0000_0000, 1'b0, 1'b1, 4, 5};
        tbl[3]  = '{8'hFF, 64'h0101_0101_0101_0101, 1'b0, 1'b1, 5, 0};
        tbl[4]  = '{8'hFF, 64'h0102_0101_0101_0201, 1'b0, 1'b1, 6, 1};
        tbl[5]  = '{8'hFF, 64'h0102_0101_0101_0201, 1'b0, 1'b1, 1, 1};
        tbl[6]  = '{8'h81, 64'h8000_0000_0000_0080, 1'b0, 1'b1, 7, 7};
        tbl[7]  = '{8'hFF, 64'h0101_0101_0101_0101, 1'b1, 1'b0, 0, 0};
        tbl[8]  = '{8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 0};
        tbl[9]  = '{8'h01, 64'h0000_0000_0000_0003, 1'b0, 1'b1, 0, 1};
        tbl[10] = '{8'h08, 64'h0000_0000_FF00_0000, 1'b0, 1'b1, 3, 7};

        rst = 1'b1;
        bus.ch_req = '0; bus.ch_pri = '0; bus.pause = 1'b0; bus.done = 1'b0;
        tick(2);
        check("reset.valid", 64'(bus.grant_valid), 64'd0);
        check("reset.ch",    64'(bus.grant_ch),    64'd0);
        check("reset.oh",    64'(bus.grant_oh),    64'd0);
        check("reset.pri",   64'(bus.grant_pri),   64'd0);
        rst = 1'b0;
        tick(1);

        // Table: each granted vector is released with done, then HOLDOFF/IDLE.
        for (int i = 0; i < 11; i++) begin
            bus.ch_req = tbl[i].req;
            bus.ch_pri = tbl[i].pri;
            bus.pause  = tbl[i].pause;
            tick(1);
            chk_grant($sformatf("vec%0d", i), tbl[i].v, tbl[i].ch, tbl[i].pr);
            if (tbl[i].v) begin
                pulse_done();
                chk_grant($sformatf("vec%0d.hold", i), 1'b0, 0, 0);
                tick(1);
            end
            bus.pause = 1'b0;
        end

        // Round robin among equal levels with two dead cycles between grants.
        do_reset();
        bus.ch_req = 8'h4A;
        bus.ch_pri = 64'h0101_0101_0101_0101;
        tick(1);
        for (int g = 0; g < 6; g++) begin
            chk_grant($sformatf("rr%0d", g), 1'b1, rr_exp[g], 0);
            pulse_done();
            chk_grant($sformatf("rr%0d.hold", g), 1'b0, 0, 0);
            tick(1);
            chk_grant($sformatf("rr%0d.idle", g), 1'b0, 0, 0);
            tick(1);
        end

        // No preemption; granted channel's priority change is ignored.
        do_reset();
        bus.ch_req = 8'h01;
        bus.ch_pri = 64'h01;
        tick(1);
        chk_grant("npre.first", 1'b1, 0, 0);
        bus.ch_req = 8'h21;
        bus.ch_pri = 64'h0000_8000_0000_0080;
        tick(3);
        chk_grant("npre.held", 1'b1, 0, 0);
        pulse_done();
        tick(2);
        chk_grant("npre.next", 1'b1, 5, 7);

        // Pause blocks new grants only; withdrawal releases without done.
        do_reset();
        bus.pause  = 1'b1;
        bus.ch_req = 8'hFF;
        bus.ch_pri = 64'h0101_0101_0101_0101;
        tick(3);
        chk_grant("pause.none", 1'b0, 0, 0);
        pulse_done();
        chk_grant("pause.done_idle", 1'b0, 0, 0);
        bus.pause = 1'b0;
        tick(1);
        chk_grant("pause.release", 1'b1, 0, 0);
        bus.pause = 1'b1;
        tick(2);
        chk_grant("pause.in_grant", 1'b1, 0, 0);
        bus.pause  = 1'b0;
        bus.ch_req = 8'hFE;
        tick(1);
        chk_grant("wd.hold", 1'b0, 0, 0);
        tick(1);
        chk_grant("wd.idle", 1'b0, 0, 0);
        tick(1);
        chk_grant("wd.next", 1'b1, 1, 0);

        // Asynchronous reset mid-grant clears outputs and the rr pointer.
        do_reset();
        bus.ch_req = 8'h08;
        bus.ch_pri = 64'h0101_0101_0101_0101;
        tick(1);
        chk_grant("arst.pre", 1'b1, 3, 0);
        #2 rst = 1'b1;
        #1;
        check("arst.valid", 64'(bus.grant_valid), 64'd0);
        check("arst.oh",    64'(bus.grant_oh),    64'd0);
        tick(1);
        rst = 1'b0;
        bus.ch_req = 8'h09;
        tick(1);
        chk_grant("arst.after", 1'b1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_dma_pri_dec_arb.md
Name: ahb_dma_pri_dec_arb

Overview:
Channel arbiter for the AHB DMA that consumes the 8-bit one-hot priority vectors produced per channel by the priority encoder subs. It decodes them back to binary levels and selects the highest-priority requesting channel, using round-robin among equal-priority channels. It then holds a registered grant until the transfer completes. It sits between the per-channel register/encoder logic and the DMA master engine.

Parameters:
NCH, 8, number of DMA channels (legal 2..16)
CHW, $clog2(NCH), width of channel index (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
ch_req  input  NCH  per-channel transfer request, level
ch_pri  input  NCH*8  per-channel one-hot priority; channel i uses bits [8i+7:8i]
pause  input  1  when high, no new grant is issued
done  input  1  single-cycle pulse from master engine: granted transfer finished
grant_valid  output  1  grant active
grant_ch  output  CHW  granted channel index
grant_oh  output  NCH  one-hot of granted channel
grant_pri  output  3  binary priority level of granted channel

Behaviour:
- Reset (async, rst=1): state=IDLE; grant_valid=0; grant_ch=0; grant_oh=0; grant_pri=0; rr pointer last_ch=NCH-1, so channel 0 wins first among equals.
- Per-channel decode (combinational): level_i = index of the highest set bit of the channel's vector. If the vector is all-zero, the channel is not eligible even when requesting. If the vector has multiple bits set, the highest bit is used.
- Eligible_i = ch_req[i] & (vector_i != 0). max_pri = highest level_i over eligible channels. Candidates = eligible channels with level_i == max_pri.
- Round-robin: the winner is the first candidate scanning last_ch+1, last_ch+2, ... modulo NCH. Wrap from NCH-1 to 0.
- FSM states: IDLE, GRANT, HOLDOFF.
- IDLE: if pause=0 and any candidate exists, register winner into grant_ch/grant_oh/grant_pri, set grant_valid=1, go to GRANT. Grant is visible the cycle after the edge at which the request was sampled (1-cycle latency). Otherwise stay in IDLE with outputs holding the last values and grant_valid=0.
- GRANT: grant outputs are frozen. A higher-priority request does not preempt. Changes to ch_pri of the granted channel are ignored.
  - If done=1, or ch_req[grant_ch]=0 (request withdrawn): at that edge grant_valid->0, last_ch<=grant_ch, go to HOLDOFF.
  - If done and withdrawal occur together, it is treated as one release.
  - pause has no effect in GRANT.
- HOLDOFF: exactly one cycle with grant_valid=0 (bus turnover), then IDLE. Requests are not evaluated in HOLDOFF. Minimum spacing between consecutive grant_valid rising edges is therefore 3 cycles after release.
- done while in IDLE/HOLDOFF: ignored.
- grant_oh is always the one-hot of grant_ch whenever grant_valid=1; it is zero when grant_valid=0.
- Reset asserted mid-GRANT: outputs drop immediately (async) and the rr pointer is reinitialised; the engine must abandon the transfer.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then ch_req=8'h05, ch0 pri=8'h04 (lvl2), ch2 pri=8'h10 (lvl4) -> one cycle later grant_valid=1, grant_ch=2, grant_oh=8'h04, grant_pri=4.
- ch1, ch3, ch6 all pri=8'h01, all requesting, done pulsed each grant -> grants in order 1,3,6,1,3,6. grant_valid low for exactly the HOLDOFF+IDLE cycles between grants.
- ch0 granted at lvl0; ch5 raises request at pri 8'h80 during GRANT -> no preemption. After done, grant_ch=5, grant_pri=7.
- ch4 requesting with pri=8'h00 and no others -> grant_valid never asserts. Setting pri=8'h24 -> grant_pri=5 (highest bit wins).
- pause=1 with ch_req=8'hFF -> no grant. Deassert pause -> grant on the following cycle. Withdraw ch_req of the granted channel without done -> release, HOLDOFF observed, next channel granted.
- Assert rst mid-GRANT (grant_ch=3) -> grant_valid=0, grant_oh=0 immediately. After release with equal-priority requests on ch0 and ch3 -> ch0 granted first.
